// File: rtl/div_pkg.sv
// Shared constants and helpers for the programmable tick/tone divider.
package div_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int MIN_PERIOD_DEF = 2;

  function automatic logic [31:0] clamp_period(
    input logic [31:0] value,
    input logic [31:0] min_val
  );
    return (value < min_val) ? min_val : value;
  endfunction

endpackage

// File: rtl/prog_divider.sv
// Runtime-programmable tick and square-wave divider with a shadowed
// period register, periodic and one-shot modes.
module prog_divider
  import div_pkg::*;
#(
  parameter int WIDTH          = 25,
  parameter int DEFAULT_PERIOD = 25_000_000,
  parameter int MIN_PERIOD     = MIN_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sclr,
  input  logic             mode,
  input  logic             start,
  input  logic [WIDTH-1:0] period_in,
  input  logic             period_valid,
  output logic             period_ready,
  output logic [WIDTH-1:0] period_q,
  output logic             tick,
  output logic             sq_out,
  output logic             busy
);

  localparam int RST_INT =
    (DEFAULT_PERIOD < MIN_PERIOD) ? MIN_PERIOD : DEFAULT_PERIOD;
  localparam logic [WIDTH-1:0] RST_P = WIDTH'(RST_INT);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             os_q, os_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;

  logic             run;
  logic             accept;
  logic             wrap;
  logic             at_half;
  logic             start_ok;
  logic [WIDTH-1:0] clamped;
  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] half;

  assign run      = en & ((mode_q == MODE_PERIODIC) | os_q);
  assign accept   = period_valid & ~pending_q;
  assign clamped  = WIDTH'(clamp_period(32'(period_in), 32'(MIN_PERIOD)));
  assign last     = per_q - ONE;
  assign half     = (per_q >> 1) - ONE;
  assign wrap     = (cnt_q == last);
  assign at_half  = (cnt_q == half);
  assign start_ok = start & (mode == MODE_ONESHOT);

  always_comb begin
    cnt_d     = cnt_q;
    per_d     = per_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    tick_d    = 1'b0;
    sq_d      = sq_q;
    os_d      = os_q;
    mode_d    = mode_q;
    busy_d    = run;

    if (sclr) begin
      cnt_d     = '0;
      sq_d      = 1'b0;
      os_d      = 1'b0;
      pending_d = 1'b0;
      busy_d    = 1'b0;
      mode_d    = mode;
    end else if (run) begin
      if (accept) begin
        pend_d    = clamped;
        pending_d = 1'b1;
      end
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        // a one-shot run ends low; a periodic one starts the high half
        sq_d   = ~os_q;
        os_d   = 1'b0;
        mode_d = mode;
        if (pending_q) begin
          per_d     = pend_q;
          pending_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + ONE;
        if (at_half) begin
          sq_d = 1'b0;
        end
      end
    end else begin
      mode_d = mode;
      if (pending_q) begin
        per_d     = pend_q;
        pending_d = 1'b0;
        cnt_d     = '0;
        sq_d      = 1'b0;
      end else if (accept) begin
        // a load arriving with start goes straight in so the run uses it
        if (start_ok) begin
          per_d = clamped;
        end else begin
          pend_d    = clamped;
          pending_d = 1'b1;
        end
      end
      if (start_ok) begin
        os_d  = 1'b1;
        cnt_d = '0;
        sq_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      per_q     <= RST_P;
      pend_q    <= RST_P;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      sq_q      <= 1'b0;
      os_q      <= 1'b0;
      mode_q    <= MODE_PERIODIC;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      os_q      <= os_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
    end
  end

  assign period_ready = ~pending_q;
  assign period_q     = per_q;
  assign tick         = tick_q;
  assign sq_out       = sq_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_prog_divider.sv
// Directed bench for prog_divider at WIDTH=8, DEFAULT_PERIOD=4.
module tb_prog_divider;

  logic       clk;
  logic       rst;
  logic       en;
  logic       sclr;
  logic       mode;
  logic       start;
  logic [7:0] period_in;
  logic       period_valid;
  logic       period_ready;
  logic [7:0] period_q;
  logic       tick;
  logic       sq_out;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  prog_divider #(
    .WIDTH(8),
    .DEFAULT_PERIOD(4),
    .MIN_PERIOD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sclr(sclr),
    .mode(mode),
    .start(start),
    .period_in(period_in),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .period_q(period_q),
    .tick(tick),
    .sq_out(sq_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; sclr = 1'b0; mode = 1'b0; start = 1'b0;
    period_in = '0; period_valid = 1'b0;
    #12;
    chk("rst_tick", tick, 0);
    chk("rst_sq", sq_out, 0);
    chk("rst_per", period_q, 4);
    chk("rst_rdy", period_ready, 1);
    chk("rst_busy", busy, 0);

    // periodic P=4
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("p4_tick", tick, (i % 4 == 0));
      chk("p4_sq", sq_out, (i >= 4 && (i % 4 == 0 || i % 4 == 1)));
    end
    chk("p4_busy", busy, 1);

    // load 7 mid-period
    step(); step();
    period_valid = 1'b1; period_in = 8'd7;
    step();
    period_valid = 1'b0;
    chk("l7_rdy_lo", period_ready, 0);
    chk("l7_per_old", period_q, 4);
    chk("l7_tick0", tick, 0);
    step();
    chk("l7_wrap_tick", tick, 1);
    chk("l7_per_new", period_q, 7);
    chk("l7_rdy_hi", period_ready, 1);
    for (int j = 1; j <= 7; j++) begin
      step();
      chk("p7_tick", tick, (j == 7));
      chk("p7_sq", sq_out, (j <= 2 || j == 7));
    end

    // load 0 clamps to 2
    period_valid = 1'b1; period_in = 8'd0;
    step();
    period_valid = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      chk("l0_tick", tick, (j == 6));
    end
    chk("l0_per", period_q, 2);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("p2_tick", tick, (k % 2 == 0));
      chk("p2_sq", sq_out, (k % 2 == 0));
    end

    // load 1 clamps to 2
    period_valid = 1'b1; period_in = 8'd1;
    step();
    period_valid = 1'b0;
    chk("l1_rdy_lo", period_ready, 0);
    step();
    chk("l1_tick", tick, 1);
    chk("l1_per", period_q, 2);
    chk("l1_rdy_hi", period_ready, 1);

    // switch to one-shot with P=5
    period_valid = 1'b1; period_in = 8'd5; mode = 1'b1;
    step();
    period_valid = 1'b0;
    step();
    chk("os_sw_tick", tick, 1);
    chk("os_sw_per", period_q, 5);
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    chk("os_clr_sq", sq_out, 0);
    chk("os_clr_busy", busy, 0);
    step();
    chk("os_idle_tick", tick, 0);
    chk("os_idle_busy", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      start = (k == 2);
      step();
      chk("os_tick", tick, (k == 5));
      chk("os_busy", busy, (k <= 5));
      chk("os_sq", sq_out, 0);
    end
    start = 1'b0;

    // back to periodic P=4, loaded while en is low
    en = 1'b0; mode = 1'b0; period_valid = 1'b1; period_in = 8'd4;
    step();
    period_valid = 1'b0;
    chk("id_rdy_lo", period_ready, 0);
    step();
    chk("id_per", period_q, 4);
    chk("id_rdy_hi", period_ready, 1);
    en = 1'b1;
    step(); step();
    en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("en0_tick", tick, 0);
      chk("en0_sq", sq_out, 0);
    end
    chk("en0_busy", busy, 0);
    en = 1'b1;
    step();
    chk("en1_tick0", tick, 0);
    step();
    chk("en1_tick1", tick, 1);
    chk("en1_sq", sq_out, 1);

    // sclr discards a pending load
    period_valid = 1'b1; period_in = 8'd9;
    step();
    period_valid = 1'b0;
    chk("sc_rdy_lo", period_ready, 0);
    step();
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    chk("sc_rdy", period_ready, 1);
    chk("sc_sq", sq_out, 0);
    chk("sc_tick", tick, 0);
    chk("sc_per", period_q, 4);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("sc_run_tick", tick, (k == 4));
    end
    chk("sc_run_per", period_q, 4);

    // apply 6, then reset mid-period
    period_valid = 1'b1; period_in = 8'd6;
    step();
    period_valid = 1'b0;
    step(); step(); step();
    chk("l6_tick", tick, 1);
    chk("l6_per", period_q, 6);
    step();
    chk("l6_sq", sq_out, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_tick", tick, 0);
    chk("ar_sq", sq_out, 0);
    chk("ar_busy", busy, 0);
    chk("ar_per", period_q, 4);
    chk("ar_rdy", period_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
